// File: rtl/gray_counter_n_pkg.sv
// rtl/gray_counter_n_pkg.sv - shared constants, count-action enum and Gray helper for gray_counter_n
package gray_counter_n_pkg;

   localparam int   DEFAULT_WIDTH = 3;
   localparam logic DIR_UP        = 1'b1;
   localparam logic DIR_DOWN      = 1'b0;

   // Action chosen for one clock edge once reset has been ruled out.
   typedef enum logic [2:0] {
      OP_HOLD,
      OP_LOAD,
      OP_INC,
      OP_DEC,
      OP_TOP,
      OP_BOTTOM
   } op_e;

   function automatic logic [15:0] gray_of(input logic [15:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gray_counter_n_if.sv
// rtl/gray_counter_n_if.sv - control and status bundle between a host and gray_counter_n
interface gray_counter_n_if
   import gray_counter_n_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             En;
   logic             Dir;
   logic             Sat;
   logic             Load;
   logic [WIDTH-1:0] LoadVal;
   logic             ClrFlags;
   logic [WIDTH-1:0] Output;
   logic [WIDTH-1:0] Binary;
   logic             Overflow;
   logic             Underflow;
   logic             Wrap;

   modport master (
      output En, Dir, Sat, Load, LoadVal, ClrFlags,
      input  Output, Binary, Overflow, Underflow, Wrap
   );

   modport slave (
      input  En, Dir, Sat, Load, LoadVal, ClrFlags,
      output Output, Binary, Overflow, Underflow, Wrap
   );

endinterface

// File: rtl/gray_counter_n_bin2gray.sv
// rtl/gray_counter_n_bin2gray.sv - combinational binary to Gray code converter
module bin2gray
   import gray_counter_n_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - up/down wrap-or-saturate counter with registered binary and Gray outputs
module gray_counter_n
   import gray_counter_n_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int INIT  = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   gray_counter_n_if.slave  bus
);

   localparam logic [WIDTH-1:0] TOP       = '1;
   localparam logic [WIDTH-1:0] BOTTOM    = '0;
   localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
   localparam logic [15:0]      INIT_G16  = gray_of(16'(INIT));
   localparam logic [WIDTH-1:0] INIT_GRAY = INIT_G16[WIDTH-1:0];

   // Declaration initialisers give the reset values at power-up.
   logic [WIDTH-1:0] binary_q    = INIT_BIN;
   logic [WIDTH-1:0] output_q    = INIT_GRAY;
   logic             overflow_q  = 1'b0;
   logic             underflow_q = 1'b0;
   logic             wrap_q      = 1'b0;

   logic [WIDTH-1:0] binary_d;
   logic [WIDTH-1:0] gray_d;
   logic             overflow_d;
   logic             underflow_d;
   logic             wrap_d;
   op_e              op;

   // Terminal values are found by compare so the arithmetic stays WIDTH bits.
   always_comb begin
      op = OP_HOLD;
      if (bus.Load) begin
         op = OP_LOAD;
      end else if (bus.En) begin
         if (bus.Dir == DIR_UP) begin
            op = (binary_q == TOP) ? OP_TOP : OP_INC;
         end else begin
            op = (binary_q == BOTTOM) ? OP_BOTTOM : OP_DEC;
         end
      end
   end

   // A flag set on this edge overrides a simultaneous ClrFlags.
   always_comb begin
      binary_d    = binary_q;
      overflow_d  = overflow_q  & ~bus.ClrFlags;
      underflow_d = underflow_q & ~bus.ClrFlags;
      wrap_d      = 1'b0;
      case (op)
         OP_LOAD: binary_d = bus.LoadVal;
         OP_INC:  binary_d = binary_q + WIDTH'(1);
         OP_DEC:  binary_d = binary_q - WIDTH'(1);
         OP_TOP: begin
            if (!bus.Sat) binary_d = BOTTOM;
            overflow_d = 1'b1;
            wrap_d     = 1'b1;
         end
         OP_BOTTOM: begin
            if (!bus.Sat) binary_d = TOP;
            underflow_d = 1'b1;
            wrap_d      = 1'b1;
         end
         default: binary_d = binary_q;
      endcase
   end

   bin2gray #(
      .WIDTH (WIDTH)
   ) u_bin2gray (
      .bin  (binary_d),
      .gray (gray_d)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         binary_q    <= INIT_BIN;
         output_q    <= INIT_GRAY;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         wrap_q      <= 1'b0;
      end else begin
         binary_q    <= binary_d;
         output_q    <= gray_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         wrap_q      <= wrap_d;
      end
   end

   assign bus.Binary    = binary_q;
   assign bus.Output    = output_q;
   assign bus.Overflow  = overflow_q;
   assign bus.Underflow = underflow_q;
   assign bus.Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - directed self-checking bench for gray_counter_n at WIDTH=3, INIT=0
module tb_gray_counter_n;

   logic Clk = 1'b0;
   logic Reset;
   int   checks   = 0;
   int   failures = 0;

   gray_counter_n_if #(.WIDTH(3)) bus ();

   gray_counter_n #(
      .WIDTH (3),
      .INIT  (0)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int b, input int g,
                            input int ovf, input int unf, input int wr);
      check({tag, ".bin"},  32'(bus.Binary),    32'(b));
      check({tag, ".gray"}, 32'(bus.Output),    32'(g));
      check({tag, ".ovf"},  32'(bus.Overflow),  32'(ovf));
      check({tag, ".unf"},  32'(bus.Underflow), 32'(unf));
      check({tag, ".wrap"}, 32'(bus.Wrap),      32'(wr));
   endtask

   int exp_bin  [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
   int exp_gray [9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
   int exp_ovf  [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
   int exp_wrap [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

   initial begin
      Reset        = 1'b1;
      bus.En       = 1'b0;
      bus.Dir      = 1'b1;
      bus.Sat      = 1'b0;
      bus.Load     = 1'b0;
      bus.LoadVal  = 3'd0;
      bus.ClrFlags = 1'b0;

      // Power-up state before any clock edge
      #1;
      check_all("powerup", 0, 0, 0, 0, 0);

      step();
      check_all("reset", 0, 0, 0, 0, 0);

      // Up-count with wrap
      Reset  = 1'b0;
      bus.En = 1'b1; bus.Dir = 1'b1; bus.Sat = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         check($sformatf("up%0d.bin", i),  32'(bus.Binary),   32'(exp_bin[i]));
         check($sformatf("up%0d.gray", i), 32'(bus.Output),   32'(exp_gray[i]));
         check($sformatf("up%0d.ovf", i),  32'(bus.Overflow), 32'(exp_ovf[i]));
         check($sformatf("up%0d.wrap", i), 32'(bus.Wrap),     32'(exp_wrap[i]));
      end

      // Down-count from reset wraps to 7
      Reset = 1'b1; bus.En = 1'b0;
      step();
      check_all("reset2", 0, 0, 0, 0, 0);
      Reset = 1'b0; bus.En = 1'b1; bus.Dir = 1'b0;
      step();
      check_all("down0", 7, 4, 0, 1, 1);
      step();
      check_all("down1", 6, 5, 0, 1, 0);

      // Load beats En; flags untouched
      bus.Load = 1'b1; bus.LoadVal = 3'd5; bus.Dir = 1'b1;
      step();
      check_all("load5", 5, 7, 0, 1, 0);
      bus.Load = 1'b0;
      step();
      check_all("after_load", 6, 5, 0, 1, 0);

      // Saturate at top for three cycles
      bus.Load = 1'b1; bus.LoadVal = 3'd7; bus.En = 1'b0;
      step();
      check_all("load7", 7, 4, 0, 1, 0);
      bus.Load = 1'b0; bus.En = 1'b1; bus.Sat = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all($sformatf("sat%0d", i), 7, 4, 1, 1, 1);
      end

      // Set wins over clear, then clear alone
      bus.ClrFlags = 1'b1;
      step();
      check_all("set_vs_clr", 7, 4, 1, 0, 1);
      bus.En = 1'b0;
      step();
      check_all("clr_only", 7, 4, 0, 0, 0);

      // Saturate at bottom, then immediate direction/mode change
      bus.ClrFlags = 1'b0;
      bus.Load = 1'b1; bus.LoadVal = 3'd0;
      step();
      check_all("load0", 0, 0, 0, 0, 0);
      bus.Load = 1'b0; bus.En = 1'b1; bus.Dir = 1'b0; bus.Sat = 1'b1;
      step();
      check_all("sat_bottom", 0, 0, 0, 1, 1);
      bus.Dir = 1'b1; bus.Sat = 1'b0;
      step();
      check_all("dir_switch", 1, 1, 0, 1, 0);
      bus.En = 1'b0; bus.Dir = 1'b0;
      step();
      check_all("hold", 1, 1, 0, 1, 0);

      // Reset mid-count overrides Load and En, no residual Wrap
      bus.Load = 1'b1; bus.LoadVal = 3'd7;
      step();
      bus.Load = 1'b0; bus.En = 1'b1; bus.Dir = 1'b1;
      Reset = 1'b1; bus.Load = 1'b1; bus.LoadVal = 3'd5;
      step();
      check_all("reset_mid", 0, 0, 0, 0, 0);
      Reset = 1'b0; bus.Load = 1'b0; bus.En = 1'b0;
      step();
      check_all("post_reset", 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gray_counter_n.md
GRAY_COUNTER_N -- requirements
Module: gray_counter_n

Interface
REQ-001 Parameter WIDTH, default 3: counter width in bits; legal range 2..16.
REQ-002 Parameter INIT, default 0: binary value loaded on Reset; SHALL be less than 2^WIDTH.
REQ-003 Clk  input  1: sole clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1: synchronous, active-high reset.
REQ-005 En  input  1: count enable.
REQ-006 Dir  input  1: count direction; 1 = up, 0 = down.
REQ-007 Sat  input  1: mode select; 1 = saturate at terminal value, 0 = wrap around.
REQ-008 Load  input  1: synchronous load strobe.
REQ-009 LoadVal  input  WIDTH: binary value to load.
REQ-010 ClrFlags  input  1: clears the sticky flags.
REQ-011 Output  output  WIDTH: registered Gray code of the internal binary count.
REQ-012 Binary  output  WIDTH: registered binary count.
REQ-013 Overflow  output  1: sticky; an up-count reached the terminal value 2^WIDTH-1 and was asked to go past it.
REQ-014 Underflow  output  1: sticky; a down-count was asked to go below 0.
REQ-015 Wrap  output  1: one-cycle pulse on any wrap or saturation event.

Function
REQ-016 Output SHALL equal Binary ^ (Binary >> 1) at all times, and both SHALL be registered with no combinational path from inputs.
REQ-017 Priority per edge SHALL be: Reset, then Load, then En; Dir, Sat and LoadVal are ignored unless selected.
REQ-018 Load=1: Binary <= LoadVal; flags unchanged except by ClrFlags; Wrap <= 0.
REQ-019 En=1, Dir=1, Binary<2^WIDTH-1: Binary <= Binary+1; Wrap <= 0.
REQ-020 En=1, Dir=1, Binary=2^WIDTH-1: Binary <= 0 if Sat=0, else holds; Overflow <= 1; Wrap <= 1.
REQ-021 En=1, Dir=0, Binary>0: Binary <= Binary-1; Wrap <= 0.
REQ-022 En=1, Dir=0, Binary=0: Binary <= 2^WIDTH-1 if Sat=0, else holds; Underflow <= 1; Wrap <= 1.
REQ-023 En=0 and Load=0: Binary holds; Wrap <= 0.
REQ-024 Arithmetic SHALL be WIDTH bits; wrap is detected by terminal-value compare, not by carry-out.
REQ-025 ClrFlags=1 SHALL clear Overflow and Underflow on that edge, unless the same edge sets a flag; a set wins over a clear.
REQ-026 Latency: every input change SHALL be visible on the outputs exactly one Clk edge later.
REQ-027 Dir or Sat changes between consecutive enabled cycles SHALL take effect immediately, without a dead cycle.

Reset
REQ-028 On Reset=1 at a Clk edge: Binary <= INIT, Output <= Gray(INIT), Overflow <= 0, Underflow <= 0, Wrap <= 0, regardless of Load, En and ClrFlags.
REQ-029 Registers SHALL power up to the same values as reset, so simulation starts defined without a reset.
REQ-030 Reset asserted mid-count SHALL abort the count with no residual Wrap pulse on the following cycle.

Structure
REQ-031 The shared include file SHALL hold the direction constants DIR_UP=1 and DIR_DOWN=0 and the default WIDTH.
REQ-032 A combinational sub-module bin2gray (parameter WIDTH) SHALL perform the Gray conversion, and gray_counter_n SHALL instantiate it once.
REQ-033 The module SHALL contain no state other than Binary, Output, Overflow, Underflow and Wrap.

Verification (WIDTH=3, INIT=0)
REQ-034 Dir=1, Sat=0, En=1 for 9 cycles -> Output 1,3,2,6,7,5,4,0,1; Overflow rises with the 0, Wrap pulses once.
REQ-035 From reset, Dir=0, Sat=0, En=1 for 2 cycles -> Binary 7,6, Output 4,5; Underflow=1 and Wrap pulses on the first cycle.
REQ-036 Load=1, LoadVal=5, En=1 together -> Binary=5, Output=7, En ignored; next up-count gives Binary=6, Output=5.
REQ-037 Sat=1, Binary=7, Dir=1, En=1 for 3 cycles -> Binary stays 7, Overflow=1, Wrap=1 on each cycle.
REQ-038 Overflow=1, then ClrFlags=1 on the same edge as a new overflow -> Overflow stays 1; ClrFlags alone on the next edge -> Overflow=0.
REQ-039 Reset=1 mid-count with Load=1 and En=1 -> all outputs 0 on the next edge, Wrap=0.
